bcd_converter: RTL

Parametrised multi-cycle binary-to-BCD converter (shift-and-add-3), successor to the fixed unsigned double-dabble block. Adds valid/ready handshakes on both sides, optional two's-complement input with a separate sign output, and a significant-digit count for display and print formatting. It sits between arithmetic/posit-decode datapaths and text or seven-segment output logic.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_add3.sv | 11 +
 rtl/bcd_converter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and sizing helper for the binary-to-BCD converter
package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FINISH = 2'd2,
      HOLD   = 2'd3
   } bcd_state_t;

   // 1233/4096 approximates log10(2), so this covers every value up to 2^width-1
   function automatic int bcd_digits(input int width);
      return (width * 1233) / 4096 + 1;
   endfunction

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - single-digit shift-and-add-3 correction
module bcd_add3
   import bcd_pkg::*;
(
   input  bcd_digit_t i_digit,
   output bcd_digit_t o_digit
);

   assign o_digit = (i_digit >= 4'd5) ? bcd_digit_t'(i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bcd_converter.sv
// rtl/bcd_converter.sv - multi-cycle binary-to-BCD converter with valid/ready handshakes
module bcd_converter
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int SIGNED = 0,
   parameter int DIGITS = bcd_digits(WIDTH),
   parameter int NDW    = $clog2(DIGITS + 1)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    in_bin,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [4*DIGITS-1:0] out_bcd,
   output logic                out_neg,
   output logic [NDW-1:0]      out_ndigits
);

   localparam int CW       = $clog2(WIDTH + 1);
   localparam bit P_SIGNED = (SIGNED != 0);

   bcd_state_t          r_state;
   logic [WIDTH-1:0]    r_mag;
   logic [4*DIGITS-1:0] r_bcd;
   logic [CW-1:0]       r_cnt;
   logic                r_neg;
   logic                r_in_ready;
   logic                r_out_valid;
   logic                r_out_neg;
   logic [4*DIGITS-1:0] r_out_bcd;
   logic [NDW-1:0]      r_out_ndigits;

   logic [4*DIGITS-1:0] w_bcd_adj;
   logic                w_in_neg;
   logic [WIDTH-1:0]    w_in_mag;
   logic [NDW-1:0]      w_ndigits;

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_add3
         bcd_add3 u_add3 (
            .i_digit (r_bcd[4*g +: 4]),
            .o_digit (w_bcd_adj[4*g +: 4])
         );
      end
   endgenerate

   // The most negative operand negates to itself, which read unsigned is the right magnitude
   assign w_in_neg = P_SIGNED & in_bin[WIDTH-1];
   assign w_in_mag = w_in_neg ? ((~in_bin) + WIDTH'(1)) : in_bin;

   always_comb begin
      w_ndigits = NDW'(1);
      for (int i = 0; i < DIGITS; i++) begin
         if (r_bcd[4*i +: 4] != 4'd0) begin
            w_ndigits = NDW'(i + 1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state       <= IDLE;
         r_mag         <= '0;
         r_bcd         <= '0;
         r_cnt         <= '0;
         r_neg         <= 1'b0;
         r_in_ready    <= 1'b0;
         r_out_valid   <= 1'b0;
         r_out_neg     <= 1'b0;
         r_out_bcd     <= '0;
         r_out_ndigits <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (r_in_ready && in_valid) begin
                  r_mag      <= w_in_mag;
                  r_neg      <= w_in_neg;
                  r_bcd      <= '0;
                  r_cnt      <= CW'(WIDTH);
                  r_in_ready <= 1'b0;
                  r_state    <= SHIFT;
               end else begin
                  r_in_ready <= 1'b1;
               end
            end
            SHIFT: begin
               r_bcd <= {w_bcd_adj[4*DIGITS-2:0], r_mag[WIDTH-1]};
               r_mag <= {r_mag[WIDTH-2:0], 1'b0};
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_state <= FINISH;
               end
            end
            FINISH: begin
               r_out_bcd     <= r_bcd;
               r_out_neg     <= r_neg;
               r_out_ndigits <= w_ndigits;
               r_out_valid   <= 1'b1;
               r_state       <= HOLD;
            end
            HOLD: begin
               // Result registers are left as-is after the handshake
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign in_ready    = r_in_ready;
   assign out_valid   = r_out_valid;
   assign out_bcd     = r_out_bcd;
   assign out_neg     = r_out_neg;
   assign out_ndigits = r_out_ndigits;

endmodule
